pll_reset_sequencer: RTL and testbench

Sits beside the PLL wrapper on the 50 MHz board reference clock. Drives the PLL's active-high reset input and qualifies its asynchronous locked output. Releases the system reset only after lock has been continuously stable for a programmable time. Re-sequences on loss of lock and flags a fault after repeated lock timeouts.

---
 rtl/pll_reset_sequencer_if.sv | 50 +++++
 rtl/pll_reset_sequencer.sv | 163 ++++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pll_reset_sequencer_if.sv
// ----------------------------------------------------------------------------
// pll_reset_sequencer_if
//   Bundles the PLL-side and system-side signals of the PLL reset sequencer.
//   The clock (refclk) and the asynchronous reset (rst) stay plain ports on
//   the sequencer itself.
//
//   Signals:
//     pll_locked    : PLL lock indication, asynchronous to refclk
//     retry_clr     : single-cycle pulse, leaves FAULT and restarts sequencing
//     pll_rst       : active-high reset to the PLL
//     sys_rst_n     : active-low reset to downstream logic
//     ready         : high while the system is running on a stable lock
//     fault         : high while sequencing has given up after repeated timeouts
//     lock_loss_cnt : saturating count of lock losses seen while running
//
//   Modports:
//     master : used by the sequencer (drives the reset/status outputs)
//     slave  : used by the environment (drives pll_locked and retry_clr)
// ----------------------------------------------------------------------------
interface pll_reset_sequencer_if #(
    parameter int unsigned CNT_W = 8
);
    logic             pll_locked;
    logic             retry_clr;
    logic             pll_rst;
    logic             sys_rst_n;
    logic             ready;
    logic             fault;
    logic [CNT_W-1:0] lock_loss_cnt;

    modport master (
        input  pll_locked,
        input  retry_clr,
        output pll_rst,
        output sys_rst_n,
        output ready,
        output fault,
        output lock_loss_cnt
    );

    modport slave (
        output pll_locked,
        output retry_clr,
        input  pll_rst,
        input  sys_rst_n,
        input  ready,
        input  fault,
        input  lock_loss_cnt
    );
endinterface

// File: rtl/pll_reset_sequencer.sv
// ----------------------------------------------------------------------------
// pll_reset_sequencer
//   Drives the PLL reset, qualifies the asynchronous lock output and releases
//   the system reset only after lock has been continuously stable for
//   STABLE_CYC cycles. Loss of lock while running re-sequences the PLL;
//   MAX_RETRY+1 consecutive lock timeouts park the block in FAULT until
//   retry_clr is pulsed.
//
//   Ports:
//     refclk : free-running reference clock (also the PLL reference)
//     rst    : asynchronous active-low reset
//     bus    : pll_reset_sequencer_if.master (pll_locked, retry_clr in;
//              pll_rst, sys_rst_n, ready, fault, lock_loss_cnt out)
// ----------------------------------------------------------------------------
module pll_reset_sequencer #(
    parameter int unsigned RST_PULSE_CYC    = 16,
    parameter int unsigned LOCK_TIMEOUT_CYC = 50000,
    parameter int unsigned STABLE_CYC       = 1024,
    parameter int unsigned MAX_RETRY        = 3,
    parameter int unsigned CNT_W            = 8
) (
    input  logic                   refclk,
    input  logic                   rst,
    pll_reset_sequencer_if.master  bus
);

    // One shared timer sized for the longest interval it has to measure.
    localparam int unsigned TMAX_A = (RST_PULSE_CYC > STABLE_CYC) ? RST_PULSE_CYC : STABLE_CYC;
    localparam int unsigned TMAX   = (TMAX_A > LOCK_TIMEOUT_CYC) ? TMAX_A : LOCK_TIMEOUT_CYC;
    localparam int unsigned TW     = $clog2(TMAX + 1);
    localparam int unsigned RW     = $clog2(MAX_RETRY + 2);

    typedef enum logic [2:0] {
        PLL_RST,
        WAIT_LOCK,
        STABLE,
        RUN,
        FAULT
    } state_t;

    state_t           state_q;
    logic [TW-1:0]    timer_q;
    logic [RW-1:0]    retry_q;
    logic [CNT_W-1:0] cnt_q;
    logic             pll_rst_q;
    logic             sys_rst_n_q;
    logic             ready_q;
    logic             fault_q;
    logic             meta_q;
    logic             lk_s_q;

    // Two-flop synchronizer for the asynchronous lock indication.
    always_ff @(posedge refclk or negedge rst) begin
        if (!rst) begin
            meta_q <= 1'b0;
            lk_s_q <= 1'b0;
        end else begin
            meta_q <= bus.pll_locked;
            lk_s_q <= meta_q;
        end
    end

    // Sequencing FSM; every output is a register updated on the transition
    // edge, so outputs change on the same edge the state does.
    always_ff @(posedge refclk or negedge rst) begin
        if (!rst) begin
            state_q     <= PLL_RST;
            timer_q     <= '0;
            retry_q     <= '0;
            cnt_q       <= '0;
            pll_rst_q   <= 1'b1;
            sys_rst_n_q <= 1'b0;
            ready_q     <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            case (state_q)
                PLL_RST: begin
                    if (timer_q == TW'(RST_PULSE_CYC - 1)) begin
                        state_q   <= WAIT_LOCK;
                        timer_q   <= '0;
                        pll_rst_q <= 1'b0;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end

                WAIT_LOCK: begin
                    // Lock takes priority over a timeout expiring on the same edge.
                    if (lk_s_q) begin
                        state_q <= STABLE;
                        timer_q <= '0;
                    end else if (timer_q == TW'(LOCK_TIMEOUT_CYC - 1)) begin
                        timer_q   <= '0;
                        pll_rst_q <= 1'b1;
                        if (retry_q == RW'(MAX_RETRY)) begin
                            state_q <= FAULT;
                            fault_q <= 1'b1;
                        end else begin
                            state_q <= PLL_RST;
                            retry_q <= retry_q + 1'b1;
                        end
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end

                STABLE: begin
                    // Any drop restarts the stability window from WAIT_LOCK.
                    if (!lk_s_q) begin
                        state_q <= WAIT_LOCK;
                        timer_q <= '0;
                    end else if (timer_q == TW'(STABLE_CYC - 1)) begin
                        state_q     <= RUN;
                        timer_q     <= '0;
                        retry_q     <= '0;
                        sys_rst_n_q <= 1'b1;
                        ready_q     <= 1'b1;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end

                RUN: begin
                    if (!lk_s_q) begin
                        state_q     <= PLL_RST;
                        timer_q     <= '0;
                        pll_rst_q   <= 1'b1;
                        sys_rst_n_q <= 1'b0;
                        ready_q     <= 1'b0;
                        if (cnt_q != '1) begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end

                FAULT: begin
                    if (bus.retry_clr) begin
                        state_q <= PLL_RST;
                        timer_q <= '0;
                        retry_q <= '0;
                        fault_q <= 1'b0;
                    end
                end

                default: begin
                    state_q     <= PLL_RST;
                    timer_q     <= '0;
                    pll_rst_q   <= 1'b1;
                    sys_rst_n_q <= 1'b0;
                    ready_q     <= 1'b0;
                    fault_q     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pll_rst       = pll_rst_q;
    assign bus.sys_rst_n     = sys_rst_n_q;
    assign bus.ready         = ready_q;
    assign bus.fault         = fault_q;
    assign bus.lock_loss_cnt = cnt_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
module tb_pll_reset_sequencer;

    localparam int unsigned P   = 16;    // RST_PULSE_CYC
    localparam int unsigned T   = 300;   // LOCK_TIMEOUT_CYC
    localparam int unsigned S   = 1024;  // STABLE_CYC
    localparam int unsigned MR  = 3;     // MAX_RETRY
    localparam int unsigned CW  = 2;     // CNT_W
    localparam int unsigned CNT_MAX = (1 << CW) - 1;

    logic refclk = 1'b0;
    logic rst;

    pll_reset_sequencer_if #(.CNT_W(CW)) bus ();

    pll_reset_sequencer #(
        .RST_PULSE_CYC   (P),
        .LOCK_TIMEOUT_CYC(T),
        .STABLE_CYC      (S),
        .MAX_RETRY       (MR),
        .CNT_W           (CW)
    ) dut (
        .refclk(refclk),
        .rst   (rst),
        .bus   (bus)
    );

    always #5 refclk = ~refclk;

    // Edge index: after posedge k, cyc == k.
    int unsigned cyc = 0;
    always @(posedge refclk) cyc <= cyc + 1;

    typedef struct packed {
        logic          prst;
        logic          srn;
        logic          rdy;
        logic          flt;
        logic [CW-1:0] cnt;
    } out_t;

    typedef struct {
        int unsigned cyc;
        out_t        o;
    } ev_t;

    ev_t         q[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned exp_cnt = 0;

    function automatic out_t mk(logic p, logic s, logic r, logic f);
        out_t o;
        o.prst = p;
        o.srn  = s;
        o.rdy  = r;
        o.flt  = f;
        o.cnt  = CW'(exp_cnt);
        return o;
    endfunction

    function automatic out_t sample();
        out_t o;
        o.prst = bus.pll_rst;
        o.srn  = bus.sys_rst_n;
        o.rdy  = bus.ready;
        o.flt  = bus.fault;
        o.cnt  = bus.lock_loss_cnt;
        return o;
    endfunction

    task automatic push(input int unsigned c, input logic p, input logic s,
                        input logic r, input logic f);
        ev_t e;
        e.cyc = c;
        e.o   = mk(p, s, r, f);
        q.push_back(e);
    endtask

    task automatic chk(input string name, input out_t got, input out_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    task automatic tick_to(input int unsigned t);
        while (cyc < t) tick();
    endtask

    task automatic loss_inc();
        if (exp_cnt < CNT_MAX) exp_cnt++;
    endtask

    // Monitor: every change of the output bundle must match the next
    // expected event, both in value and in edge index.
    initial begin
        out_t prev, cur;
        ev_t  e;
        prev = mk(1'b1, 1'b0, 1'b0, 1'b0);
        forever begin
            @(negedge refclk);
            cur = sample();
            if (cur !== prev) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event: got %b at cycle %0d, none required", cur, cyc);
                end else begin
                    e = q.pop_front();
                    if (e.cyc != cyc || e.o !== cur) begin
                        errors++;
                        $display("FAIL event: got %b at cycle %0d, required %b at cycle %0d",
                                 cur, cyc, e.o, e.cyc);
                    end
                end
                prev = cur;
            end
        end
    end

    // Asserts rst mid-cycle and checks the outputs before any clock edge.
    task automatic async_reset_check(input string name);
        @(posedge refclk);
        #3;
        exp_cnt = 0;
        push(cyc, 1'b1, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        chk(name, sample(), mk(1'b1, 1'b0, 1'b0, 1'b0));
    endtask

    // From RUN: hold lock low -> MR+1 pll_rst pulses, FAULT, retry_clr,
    // one timeout that must not fault, then lock exactly at the timeout edge.
    task automatic fault_and_recover(input int unsigned run_in, output int unsigned run_out);
        int unsigned c, p, w, w2;
        tick_to(run_in + $urandom_range(5, 60));
        c = cyc;
        bus.pll_locked = 1'b0;
        loss_inc();
        p = c + 3;
        push(p, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int unsigned a = 0; a <= MR; a++) begin
            push(p + P, 1'b0, 1'b0, 1'b0, 1'b0);
            if (a < MR) begin
                p = p + P + T;
                push(p, 1'b1, 1'b0, 1'b0, 1'b0);
            end else begin
                push(p + P + T, 1'b1, 1'b0, 1'b0, 1'b1);
            end
        end
        tick_to(p + P + T + $urandom_range(3, 40));
        c = cyc;
        bus.retry_clr = 1'b1;
        tick();
        bus.retry_clr = 1'b0;
        push(c + 1, 1'b1, 1'b0, 1'b0, 1'b0);
        w = c + 1 + P;
        push(w, 1'b0, 1'b0, 1'b0, 1'b0);
        push(w + T, 1'b1, 1'b0, 1'b0, 1'b0);
        w2 = w + T + P;
        push(w2, 1'b0, 1'b0, 1'b0, 1'b0);
        tick_to(w2 + T - 3);
        bus.pll_locked = 1'b1;
        run_out = w2 + T + S;
        push(run_out, 1'b0, 1'b1, 1'b1, 1'b0);
    endtask

    initial begin
        int unsigned r, c, s0, k, w, run_at;
        rst            = 1'b1;
        bus.pll_locked = 1'b0;
        bus.retry_clr  = 1'b0;
        #1 rst = 1'b0;
        repeat (3) tick();
        chk("reset_state", sample(), mk(1'b1, 1'b0, 1'b0, 1'b0));

        // Power-up: 16-cycle PLL reset, lock 200 cycles after release.
        r   = cyc;
        rst = 1'b1;
        push(r + P, 1'b0, 1'b0, 1'b0, 1'b0);
        tick_to(r + 200);
        bus.pll_locked = 1'b1;
        run_at = cyc + 3 + S;
        push(run_at, 1'b0, 1'b1, 1'b1, 1'b0);

        // Five short lock losses in RUN; two of the re-sequences also see a
        // one-cycle glitch inside the STABLE window.
        for (int unsigned i = 0; i < 5; i++) begin
            tick_to(run_at + $urandom_range(5, 60));
            if (i == 1) begin
                bus.retry_clr = 1'b1;
                tick();
                bus.retry_clr = 1'b0;
            end
            c = cyc;
            w = $urandom_range(1, 3);
            bus.pll_locked = 1'b0;
            loss_inc();
            push(c + 3, 1'b1, 1'b0, 1'b0, 1'b0);
            push(c + 3 + P, 1'b0, 1'b0, 1'b0, 1'b0);
            s0 = c + 3 + P + 1;
            repeat (w) tick();
            bus.pll_locked = 1'b1;
            if (i == 2 || i == 4) begin
                k = (i == 2) ? 500 : $urandom_range(1, S - 1);
                tick_to(s0 + k - 3);
                bus.pll_locked = 1'b0;
                tick();
                bus.pll_locked = 1'b1;
                run_at = s0 + k + 1 + S;
            end else begin
                run_at = s0 + S;
            end
            push(run_at, 1'b0, 1'b1, 1'b1, 1'b0);
        end

        fault_and_recover(run_at, run_at);
        fault_and_recover(run_at, run_at);

        // Asynchronous reset mid-RUN, then mid-STABLE.
        tick_to(run_at + $urandom_range(5, 60));
        async_reset_check("rst_mid_run");
        repeat (3) tick();
        r   = cyc;
        rst = 1'b1;
        push(r + P, 1'b0, 1'b0, 1'b0, 1'b0);
        s0 = r + P + 1;
        tick_to(s0 + $urandom_range(10, S - 10));
        async_reset_check("rst_mid_stable");
        repeat (3) tick();
        r   = cyc;
        rst = 1'b1;
        push(r + P, 1'b0, 1'b0, 1'b0, 1'b0);
        run_at = r + P + 1 + S;
        push(run_at, 1'b0, 1'b1, 1'b1, 1'b0);

        // Counter restarts from zero after reset.
        tick_to(run_at + 10);
        c = cyc;
        bus.pll_locked = 1'b0;
        tick();
        bus.pll_locked = 1'b1;
        loss_inc();
        push(c + 3, 1'b1, 1'b0, 1'b0, 1'b0);
        push(c + 3 + P, 1'b0, 1'b0, 1'b0, 1'b0);
        run_at = c + 3 + P + 1 + S;
        push(run_at, 1'b0, 1'b1, 1'b1, 1'b0);

        tick_to(run_at + 5);
        for (int n = 0; n < 100 && q.size() != 0; n++) tick();
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL pending_events: got %0d outstanding, required 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #(60000 * 10);
        $display("FAIL watchdog: got no completion by cycle %0d, required completion", cyc);
        $fatal(1, "timeout");
    end

endmodule
